// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared FSM encoding, product indices and rounding helper for cx_mixer
package dsp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P0   = 3'd1,
    ST_P1   = 3'd2,
    ST_P2   = 3'd3,
    ST_P3   = 3'd4
  } state_t;

  // Operand pairings fed to the shared multiplier
  localparam logic [1:0] PRD_XI_LI = 2'd0;
  localparam logic [1:0] PRD_XQ_LQ = 2'd1;
  localparam logic [1:0] PRD_XI_LQ = 2'd2;
  localparam logic [1:0] PRD_XQ_LI = 2'd3;

  // Half an LSB of the output once the Q1.(LOSZ-1) LO scale is removed
  function automatic int round_offset(input int losz);
    return 1 << (losz - 2);
  endfunction

endpackage

// File: rtl/cx_mixer_if.sv
// rtl/cx_mixer_if.sv - sample/LO input handshake and mixed output bundle
interface cx_mixer_if #(
  parameter int DSZ  = 16,
  parameter int LOSZ = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic signed [DSZ-1:0]  in_i;
  logic signed [DSZ-1:0]  in_q;
  logic signed [LOSZ-1:0] lo_i;
  logic signed [LOSZ-1:0] lo_q;
  logic                   mode_real;
  logic                   mode_conj;
  logic                   out_valid;
  logic signed [DSZ-1:0]  out_i;
  logic signed [DSZ-1:0]  out_q;

  modport master (
    output in_valid, in_i, in_q, lo_i, lo_q, mode_real, mode_conj,
    input  in_ready, out_valid, out_i, out_q
  );

  modport slave (
    input  in_valid, in_i, in_q, lo_i, lo_q, mode_real, mode_conj,
    output in_ready, out_valid, out_i, out_q
  );
endinterface

// File: rtl/saturator.sv
// rtl/saturator.sv - signed clamp from ISZ to OSZ bits
module saturator #(
  parameter int ISZ = 18,
  parameter int OSZ = 16
) (
  input  logic signed [ISZ-1:0] din,
  output logic signed [OSZ-1:0] dout
);

  always_comb begin
    if (&din[ISZ-1:OSZ-1] || ~|din[ISZ-1:OSZ-1]) begin
      dout = din[OSZ-1:0];
    end else if (din[ISZ-1]) begin
      dout = {1'b1, {(OSZ-1){1'b0}}};
    end else begin
      dout = {1'b0, {(OSZ-1){1'b1}}};
    end
  end

endmodule

// File: rtl/cx_mixer.sv
// rtl/cx_mixer.sv - complex mixer with one time-shared signed multiplier,
// round-half-up and saturation; 4 cycles/sample complex, 2 cycles/sample real
module cx_mixer
  import dsp_pkg::*;
#(
  parameter int DSZ  = 16,
  parameter int LOSZ = 16
) (
  input logic        clk,
  input logic        reset_n,
  cx_mixer_if.slave  mix
);

  localparam int PW = DSZ + LOSZ;
  localparam int AW = PW + 1;
  localparam logic signed [AW-1:0] RND = AW'(round_offset(LOSZ));

  state_t state_q, state_d;
  logic   accept, last_issue, issue;
  logic [1:0] sel;
  logic   i_first, i_neg, i_done_i, i_done_q;

  logic signed [DSZ-1:0]  xi_q, xi_d, xq_q, xq_d;
  logic signed [LOSZ-1:0] li_q, li_d, lq_q, lq_d;
  logic                   real_q, real_d, conj_q, conj_d;

  logic signed [PW-1:0] prod_q, prod_d;
  logic pv_q, pv_d, pfirst_q, pfirst_d, pneg_q, pneg_d, pdi_q, pdi_d, pdq_q, pdq_d;

  logic signed [AW-1:0] acc_q, acc_d, acc_base;
  logic adi_q, adi_d, adq_q, adq_d;

  logic signed [DSZ-1:0] ihold_q, ihold_d, oi_q, oi_d, oq_q, oq_d;
  logic                  ov_q, ov_d;

  logic signed [DSZ-1:0]  mul_a;
  logic signed [LOSZ-1:0] mul_b;
  logic signed [DSZ+1:0]  sat_in;
  logic signed [DSZ-1:0]  sat_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_P0;
      ST_P0:   state_d = ST_P1;
      ST_P1:   state_d = real_q ? (accept ? ST_P0 : ST_IDLE) : ST_P2;
      ST_P2:   state_d = ST_P3;
      ST_P3:   state_d = accept ? ST_P0 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Each issued product carries its own accumulate tags down the pipe,
  // so a new sample can start while the previous one drains.
  always_comb begin
    last_issue   = (state_q == ST_P3) || (state_q == ST_P1 && real_q);
    mix.in_ready = reset_n && ((state_q == ST_IDLE) || last_issue);
    issue        = (state_q != ST_IDLE);
    sel      = PRD_XI_LI;
    i_first  = 1'b0;
    i_neg    = 1'b0;
    i_done_i = 1'b0;
    i_done_q = 1'b0;
    case (state_q)
      ST_P0: begin
        i_first  = 1'b1;
        i_done_i = real_q;
      end
      ST_P1: begin
        if (real_q) begin
          sel      = PRD_XI_LQ;
          i_first  = 1'b1;
          i_neg    = conj_q;
          i_done_q = 1'b1;
        end else begin
          sel      = PRD_XQ_LQ;
          i_neg    = !conj_q;
          i_done_i = 1'b1;
        end
      end
      ST_P2: begin
        sel     = PRD_XI_LQ;
        i_first = 1'b1;
        i_neg   = conj_q;
      end
      ST_P3: begin
        sel      = PRD_XQ_LI;
        i_done_q = 1'b1;
      end
      default: ;
    endcase
  end

  assign accept = mix.in_valid && mix.in_ready;

  always_comb begin
    case (sel)
      PRD_XI_LI: begin mul_a = xi_q; mul_b = li_q; end
      PRD_XQ_LQ: begin mul_a = xq_q; mul_b = lq_q; end
      PRD_XI_LQ: begin mul_a = xi_q; mul_b = lq_q; end
      default:   begin mul_a = xq_q; mul_b = li_q; end
    endcase

    xi_d   = accept ? mix.in_i      : xi_q;
    xq_d   = accept ? mix.in_q      : xq_q;
    li_d   = accept ? mix.lo_i      : li_q;
    lq_d   = accept ? mix.lo_q      : lq_q;
    real_d = accept ? mix.mode_real : real_q;
    conj_d = accept ? mix.mode_conj : conj_q;

    prod_d   = issue ? PW'(mul_a) * PW'(mul_b) : prod_q;
    pv_d     = issue;
    pfirst_d = i_first;
    pneg_d   = i_neg;
    pdi_d    = i_done_i;
    pdq_d    = i_done_q;

    acc_base = pfirst_q ? '0 : acc_q;
    acc_d    = acc_q;
    if (pv_q) acc_d = pneg_q ? acc_base - AW'(prod_q) : acc_base + AW'(prod_q);
    adi_d = pv_q && pdi_q;
    adq_d = pv_q && pdq_q;

    sat_in  = (DSZ+2)'((acc_q + RND) >>> (LOSZ-1));
    ihold_d = adi_q ? sat_out : ihold_q;
    ov_d    = adq_q;
    oi_d    = adq_q ? ihold_q : oi_q;
    oq_d    = adq_q ? sat_out : oq_q;
  end

  saturator #(.ISZ(DSZ+2), .OSZ(DSZ)) u_sat (
    .din  (sat_in),
    .dout (sat_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xi_q <= '0; xq_q <= '0; li_q <= '0; lq_q <= '0;
      real_q <= 1'b0; conj_q <= 1'b0;
      prod_q <= '0; pv_q <= 1'b0; pfirst_q <= 1'b0; pneg_q <= 1'b0;
      pdi_q <= 1'b0; pdq_q <= 1'b0;
      acc_q <= '0; adi_q <= 1'b0; adq_q <= 1'b0;
      ihold_q <= '0; oi_q <= '0; oq_q <= '0; ov_q <= 1'b0;
    end else begin
      xi_q <= xi_d; xq_q <= xq_d; li_q <= li_d; lq_q <= lq_d;
      real_q <= real_d; conj_q <= conj_d;
      prod_q <= prod_d; pv_q <= pv_d; pfirst_q <= pfirst_d; pneg_q <= pneg_d;
      pdi_q <= pdi_d; pdq_q <= pdq_d;
      acc_q <= acc_d; adi_q <= adi_d; adq_q <= adq_d;
      ihold_q <= ihold_d; oi_q <= oi_d; oq_q <= oq_d; ov_q <= ov_d;
    end
  end

  assign mix.out_valid = ov_q;
  assign mix.out_i     = oi_q;
  assign mix.out_q     = oq_q;

endmodule

// File: tb/tb_cx_mixer.sv
// tb/tb_cx_mixer.sv - randomized and directed bench for cx_mixer against an arithmetic model
module tb_cx_mixer;

  localparam int DSZ  = 16;
  localparam int LOSZ = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  int                    acc_log[$];
  int                    out_cyc[$];
  logic signed [DSZ-1:0] out_iv[$];
  logic signed [DSZ-1:0] out_qv[$];

  cx_mixer_if #(.DSZ(DSZ), .LOSZ(LOSZ)) mix ();

  cx_mixer #(.DSZ(DSZ), .LOSZ(LOSZ)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mix     (mix)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mix.in_valid && mix.in_ready) acc_log.push_back(cyc);
    if (mix.out_valid) begin
      out_cyc.push_back(cyc);
      out_iv.push_back(mix.out_i);
      out_qv.push_back(mix.out_q);
    end
  end

  function automatic logic signed [DSZ-1:0] scale(input longint v);
    longint r;
    r = (v + (longint'(1) <<< (LOSZ-2))) >>> (LOSZ-1);
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return DSZ'(r);
  endfunction

  function automatic void model(input logic signed [DSZ-1:0] xi, xq,
                                input logic signed [LOSZ-1:0] li, lq,
                                input logic rm, cj,
                                output logic signed [DSZ-1:0] ei, eq);
    longint a, b, c, d, vi, vq;
    a = xi; b = rm ? 0 : xq; c = li; d = lq;
    if (cj) begin vi = a*c + b*d; vq = b*c - a*d; end
    else    begin vi = a*c - b*d; vq = a*d + b*c; end
    ei = scale(vi);
    eq = scale(vq);
  endfunction

  function automatic logic [15:0] pick_val();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 16'h8000;
    if (r == 1) return 16'h7FFF;
    return 16'($urandom);
  endfunction

  task automatic clear_logs();
    acc_log.delete(); out_cyc.delete(); out_iv.delete(); out_qv.delete();
  endtask

  task automatic send(input logic [15:0] xi, xq, li, lq, input logic rm, cj, output bit ok);
    int n;
    n = 0; ok = 1'b0;
    mix.in_i = xi; mix.in_q = xq; mix.lo_i = li; mix.lo_q = lq;
    mix.mode_real = rm; mix.mode_conj = cj; mix.in_valid = 1'b1;
    while (n < 20 && !ok) begin
      @(negedge clk);
      if (mix.in_ready) ok = 1'b1;
      n++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    mix.in_valid = 1'b1; mix.in_i = 16'h1234; mix.in_q = 16'h4321;
    mix.lo_i = 16'h7FFF; mix.lo_q = 16'h0001; mix.mode_real = 1'b0; mix.mode_conj = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (mix.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b want 0", mix.in_ready); end
      vectors++;
      if (mix.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", mix.out_valid); end
      vectors++;
      if (mix.out_i !== 16'h0) begin miscompares++; $display("FAIL reset_out_i got %h want 0000", mix.out_i); end
      vectors++;
      if (mix.out_q !== 16'h0) begin miscompares++; $display("FAIL reset_out_q got %h want 0000", mix.out_q); end
    end
    @(posedge clk); #1;
    mix.in_valid = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    clear_logs();
  endtask

  task automatic test_directed();
    logic [15:0] t_xi[5], t_xq[5], t_li[5], t_lq[5], t_ei[5], t_eq[5];
    logic        t_rm[5], t_cj[5];
    bit ok;
    t_xi = '{16'h4000, 16'h8000, 16'h8000, 16'h2000, 16'h2000};
    t_xq = '{16'h0000, 16'h8000, 16'h8000, 16'h1234, 16'h1234};
    t_li = '{16'h7FFF, 16'h8000, 16'h8000, 16'h0000, 16'h0000};
    t_lq = '{16'h0000, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF};
    t_rm = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    t_cj = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    t_ei = '{16'h4000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000};
    t_eq = '{16'h0000, 16'h7FFF, 16'h0000, 16'h2000, 16'hE000};
    for (int k = 0; k < 5; k++) begin
      clear_logs();
      send(t_xi[k], t_xq[k], t_li[k], t_lq[k], t_rm[k], t_cj[k], ok);
      mix.in_valid = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      vectors++;
      if (!ok || out_cyc.size() != 1 || acc_log.size() != 1) begin
        miscompares++;
        $display("FAIL directed%0d_pulses got accepted=%0d pulses=%0d want 1 pulse", k, ok, out_cyc.size());
      end else begin
        vectors++;
        if (out_iv[0] !== t_ei[k]) begin miscompares++; $display("FAIL directed%0d_i got %h want %h", k, out_iv[0], t_ei[k]); end
        vectors++;
        if (out_qv[0] !== t_eq[k]) begin miscompares++; $display("FAIL directed%0d_q got %h want %h", k, out_qv[0], t_eq[k]); end
        vectors++;
        if (out_cyc[0] - acc_log[0] !== (t_rm[k] ? 5 : 7)) begin
          miscompares++;
          $display("FAIL directed%0d_latency got %0d want %0d", k, out_cyc[0] - acc_log[0], t_rm[k] ? 5 : 7);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] xi[16], xq[16], li[16], lq[16];
    logic        rm[16], cj[16];
    logic signed [DSZ-1:0] ei[16], eq[16];
    bit ok, all_ok;
    int n;
    clear_logs();
    all_ok = 1'b1;
    for (int k = 0; k < 16; k++) begin
      xi[k] = pick_val(); xq[k] = pick_val(); li[k] = pick_val(); lq[k] = pick_val();
      rm[k] = (k == 8); cj[k] = 1'($urandom);
      model(xi[k], xq[k], li[k], lq[k], rm[k], cj[k], ei[k], eq[k]);
    end
    for (int k = 0; k < 16; k++) begin
      send(xi[k], xq[k], li[k], lq[k], rm[k], cj[k], ok);
      all_ok &= ok;
    end
    mix.in_valid = 1'b0;
    n = 0;
    while (n < 40 && out_cyc.size() < 16) begin @(posedge clk); n++; end
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (!all_ok || acc_log.size() != 16 || out_cyc.size() != 16) begin
      miscompares++;
      $display("FAIL b2b_counts got accepts=%0d pulses=%0d want 16 and 16", acc_log.size(), out_cyc.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (k > 0) begin
          vectors++;
          if (acc_log[k] - acc_log[k-1] !== (rm[k-1] ? 2 : 4)) begin
            miscompares++;
            $display("FAIL b2b_spacing%0d got %0d want %0d", k, acc_log[k] - acc_log[k-1], rm[k-1] ? 2 : 4);
          end
        end
        vectors++;
        if (out_iv[k] !== ei[k] || out_qv[k] !== eq[k]) begin
          miscompares++;
          $display("FAIL b2b_value%0d got %h,%h want %h,%h", k, out_iv[k], out_qv[k], ei[k], eq[k]);
        end
        vectors++;
        if (out_cyc[k] - acc_log[k] !== (rm[k] ? 5 : 7)) begin
          miscompares++;
          $display("FAIL b2b_latency%0d got %0d want %0d", k, out_cyc[k] - acc_log[k], rm[k] ? 5 : 7);
        end
      end
    end
  endtask

  task automatic test_random();
    localparam int N = 30;
    logic rm[N];
    logic signed [DSZ-1:0] ei[N], eq[N];
    logic [15:0] xi, xq, li, lq;
    logic cj;
    bit ok, all_ok;
    int gap, n;
    clear_logs();
    all_ok = 1'b1;
    for (int k = 0; k < N; k++) begin
      xi = pick_val(); xq = pick_val(); li = pick_val(); lq = pick_val();
      rm[k] = ($urandom_range(0, 2) == 0); cj = 1'($urandom);
      model(xi, xq, li, lq, rm[k], cj, ei[k], eq[k]);
      send(xi, xq, li, lq, rm[k], cj, ok);
      all_ok &= ok;
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        mix.in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    mix.in_valid = 1'b0;
    n = 0;
    while (n < 40 && out_cyc.size() < N) begin @(posedge clk); n++; end
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (!all_ok || acc_log.size() != N || out_cyc.size() != N) begin
      miscompares++;
      $display("FAIL rand_counts got accepts=%0d pulses=%0d want %0d", acc_log.size(), out_cyc.size(), N);
    end else begin
      for (int k = 0; k < N; k++) begin
        vectors++;
        if (out_iv[k] !== ei[k] || out_qv[k] !== eq[k]) begin
          miscompares++;
          $display("FAIL rand_value%0d got %h,%h want %h,%h", k, out_iv[k], out_qv[k], ei[k], eq[k]);
        end
        vectors++;
        if (out_cyc[k] - acc_log[k] !== (rm[k] ? 5 : 7)) begin
          miscompares++;
          $display("FAIL rand_latency%0d got %0d want %0d", k, out_cyc[k] - acc_log[k], rm[k] ? 5 : 7);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic signed [DSZ-1:0] ei, eq;
    logic [15:0] xi, xq, li, lq;
    bit ok;
    clear_logs();
    send(16'h3000, 16'hD000, 16'h5A5A, 16'h2222, 1'b0, 1'b0, ok);
    mix.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (mix.in_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_in_ready got %b want 0", mix.in_ready); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    vectors++;
    if (!ok || out_cyc.size() != 0) begin
      miscompares++;
      $display("FAIL midrst_discard got accepted=%0d pulses=%0d want 0 pulses", ok, out_cyc.size());
    end
    vectors++;
    if (mix.out_i !== 16'h0 || mix.out_q !== 16'h0) begin
      miscompares++;
      $display("FAIL midrst_outputs got %h,%h want 0000,0000", mix.out_i, mix.out_q);
    end
    clear_logs();
    xi = pick_val(); xq = pick_val(); li = pick_val(); lq = pick_val();
    model(xi, xq, li, lq, 1'b0, 1'b1, ei, eq);
    send(xi, xq, li, lq, 1'b0, 1'b1, ok);
    mix.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    vectors++;
    if (!ok || out_cyc.size() != 1) begin
      miscompares++;
      $display("FAIL midrst_after_pulses got accepted=%0d pulses=%0d want 1", ok, out_cyc.size());
    end else begin
      vectors++;
      if (out_iv[0] !== ei || out_qv[0] !== eq) begin
        miscompares++;
        $display("FAIL midrst_after_value got %h,%h want %h,%h", out_iv[0], out_qv[0], ei, eq);
      end
      vectors++;
      if (out_cyc[0] - acc_log[0] !== 7) begin
        miscompares++;
        $display("FAIL midrst_after_latency got %0d want 7", out_cyc[0] - acc_log[0]);
      end
    end
  endtask

  initial begin
    mix.in_valid = 1'b0; mix.in_i = '0; mix.in_q = '0; mix.lo_i = '0; mix.lo_q = '0;
    mix.mode_real = 1'b0; mix.mode_conj = 1'b0;
    #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
